// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard / pipeline-control unit.
// Also used by the optional performance counters enabled with HAZARD_PERF_EN.
package hazard_pkg;

  typedef enum logic {RUN, LDSTALL} state_e;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic pc_write;
    logic ifid_load;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = ctrl_t'(5'b11000);
  localparam ctrl_t CTRL_STALL  = ctrl_t'(5'b00010);
  localparam ctrl_t CTRL_FLUSH  = ctrl_t'(5'b11110);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(5'b00001);
  localparam ctrl_t CTRL_RESET  = ctrl_t'(5'b00110);

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit bundle: ID-stage operand info in, PC/IF/ID/ID/EX controls out.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2
);
  logic [NUM_SRC*REG_ADDR_W-1:0] IFIDRs;
  logic [NUM_SRC-1:0]            IFIDRsUsed;
  logic [REG_ADDR_W-1:0]         IDExRt;
  logic                          IDExMemRead;
  logic                          BranchTaken;
  logic                          MemBusy;
  logic                          PcWrite;
  logic                          IFIDLoad;
  logic                          IFIDFlush;
  logic                          IDExFlush;
  logic                          PipeHold;

  modport master (
    output IFIDRs, IFIDRsUsed, IDExRt, IDExMemRead, BranchTaken, MemBusy,
    input  PcWrite, IFIDLoad, IFIDFlush, IDExFlush, PipeHold
  );

  modport slave (
    input  IFIDRs, IFIDRsUsed, IDExRt, IDExMemRead, BranchTaken, MemBusy,
    output PcWrite, IFIDLoad, IFIDFlush, IDExFlush, PipeHold
  );
endinterface

// File: rtl/hazard_match.sv
// NUM_SRC-way compare of IF/ID source operands against the ID/EX load destination.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2
) (
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_i,
  input  logic [NUM_SRC-1:0]            used_i,
  input  logic [REG_ADDR_W-1:0]         rt_i,
  input  logic                          mem_read_i,
  output logic                          hazard_o
);

  logic [NUM_SRC-1:0] hit;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign hit[g] = used_i[g] && (rs_i[g*REG_ADDR_W +: REG_ADDR_W] == rt_i);
  end

  // r0 is hardwired, so a load targeting it never creates a dependency
  assign hazard_o = mem_read_i && (rt_i != REG_ADDR_W'(REG_ZERO)) && (|hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use hazard / pipeline control: freeze > branch flush > multi-cycle load stall > run.
// Define HAZARD_PERF_EN to add saturating PerfStall/PerfFlush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef HAZARD_PERF_EN
  output logic [15:0] PerfStall,
  output logic [15:0] PerfFlush,
`endif
  hazard_ctrl_if.slave hz
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  ctrl_t            ctrl, ctrl_out;

  hazard_match #(.REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC)) u_match (
    .rs_i       (hz.IFIDRs),
    .used_i     (hz.IFIDRsUsed),
    .rt_i       (hz.IDExRt),
    .mem_read_i (hz.IDExMemRead),
    .hazard_o   (hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz.MemBusy) begin
      ctrl = CTRL_FREEZE;
    end else if (hz.BranchTaken) begin
      ctrl    = CTRL_FLUSH;
      state_d = RUN;
      cnt_d   = '0;
    end else if (state_q == LDSTALL) begin
      // detection cycle already supplied the first bubble; cnt_q covers the rest
      ctrl  = CTRL_STALL;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) state_d = RUN;
    end else if (hazard) begin
      ctrl = CTRL_STALL;
      if (LOAD_LAT > 1) begin
        state_d = LDSTALL;
        cnt_d   = CNT_W'(LOAD_LAT - 1);
      end
    end
  end

  assign ctrl_out     = rst_n ? ctrl : CTRL_RESET;
  assign hz.PcWrite   = ctrl_out.pc_write;
  assign hz.IFIDLoad  = ctrl_out.ifid_load;
  assign hz.IFIDFlush = ctrl_out.ifid_flush;
  assign hz.IDExFlush = ctrl_out.idex_flush;
  assign hz.PipeHold  = ctrl_out.pipe_hold;

`ifdef HAZARD_PERF_EN
  logic        stall_ev, flush_ev;
  logic [15:0] perf_stall_q, perf_flush_q;

  assign stall_ev = !hz.MemBusy && !hz.BranchTaken && ((state_q == LDSTALL) || hazard);
  assign flush_ev = !hz.MemBusy && hz.BranchTaken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_ev && perf_stall_q != 16'hFFFF) perf_stall_q <= perf_stall_q + 16'd1;
      if (flush_ev && perf_flush_q != 16'hFFFF) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign PerfStall = perf_stall_q;
  assign PerfFlush = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: LOAD_LAT=1 and LOAD_LAT=3 instances share one stimulus stream.
module tb_hazard_ctrl;

  localparam logic [4:0] R = 5'b11000;  // run
  localparam logic [4:0] S = 5'b00010;  // load-use stall
  localparam logic [4:0] F = 5'b11110;  // branch flush
  localparam logic [4:0] Z = 5'b00001;  // memory freeze
  localparam logic [4:0] X = 5'b00110;  // reset

  typedef struct {
    logic       mr;
    logic [4:0] rt;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic       br;
    logic       busy;
    logic [4:0] e1;
    logic [4:0] e3;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mr = 1'b0, br = 1'b0, busy = 1'b0;
  logic [4:0] rt = '0, rs0 = '0, rs1 = '0;
  logic [1:0] used = '0;
  int         checks = 0;
  int         errors = 0;
  vec_t       vecs[16];

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(5), .NUM_SRC(2)) if1 ();
  hazard_ctrl_if #(.REG_ADDR_W(5), .NUM_SRC(2)) if3 ();

  assign if1.IFIDRs = {rs1, rs0};  assign if3.IFIDRs = {rs1, rs0};
  assign if1.IFIDRsUsed = used;    assign if3.IFIDRsUsed = used;
  assign if1.IDExRt = rt;          assign if3.IDExRt = rt;
  assign if1.IDExMemRead = mr;     assign if3.IDExMemRead = mr;
  assign if1.BranchTaken = br;     assign if3.BranchTaken = br;
  assign if1.MemBusy = busy;       assign if3.MemBusy = busy;

`ifdef HAZARD_PERF_EN
  logic [15:0] ps1, pf1, ps3, pf3;
`endif

  hazard_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef HAZARD_PERF_EN
    .PerfStall(ps1), .PerfFlush(pf1),
`endif
    .hz(if1)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
`ifdef HAZARD_PERF_EN
    .PerfStall(ps3), .PerfFlush(pf3),
`endif
    .hz(if3)
  );

  function automatic logic [4:0] out1();
    return {if1.PcWrite, if1.IFIDLoad, if1.IFIDFlush, if1.IDExFlush, if1.PipeHold};
  endfunction

  function automatic logic [4:0] out3();
    return {if3.PcWrite, if3.IFIDLoad, if3.IFIDFlush, if3.IDExFlush, if3.PipeHold};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // apply inputs on the falling edge, sample outputs 1ns later
  task automatic apply(input logic m, input logic [4:0] t, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [1:0] u, input logic b,
                       input logic y);
    @(negedge clk);
    mr = m; rt = t; rs0 = s0; rs1 = s1; used = u; br = b; busy = y;
    #1;
  endtask

  initial begin
    //            mr  rt  rs0 rs1 used   br busy  e1 e3
    vecs[0]  = '{0, 5, 3, 5, 2'b11, 0, 0, R, R};  // no load
    vecs[1]  = '{1, 0, 0, 3, 2'b11, 0, 0, R, R};  // load to r0
    vecs[2]  = '{1, 5, 3, 5, 2'b01, 0, 0, R, R};  // match only on unused operand
    vecs[3]  = '{1, 5, 3, 5, 2'b11, 0, 0, S, S};  // hazard on operand 1
    vecs[4]  = '{0, 5, 3, 5, 2'b11, 0, 0, R, S};
    vecs[5]  = '{0, 5, 3, 5, 2'b11, 0, 0, R, S};
    vecs[6]  = '{0, 5, 3, 5, 2'b11, 0, 0, R, R};
    vecs[7]  = '{1, 7, 7, 2, 2'b11, 0, 0, S, S};  // hazard on operand 0
    vecs[8]  = '{1, 7, 7, 2, 2'b11, 0, 0, S, S};  // repeat load, u3 mid-stall
    vecs[9]  = '{0, 7, 7, 2, 2'b11, 0, 0, R, S};  // u3 last bubble
    vecs[10] = '{1, 7, 7, 2, 2'b11, 0, 0, S, S};  // back-to-back fresh stall
    vecs[11] = '{0, 7, 7, 2, 2'b11, 1, 0, F, F};  // branch in 2nd stall cycle
    vecs[12] = '{0, 7, 7, 2, 2'b11, 0, 0, R, R};  // no residual stall
    vecs[13] = '{1, 7, 7, 2, 2'b11, 0, 1, Z, Z};  // freeze beats hazard
    vecs[14] = '{0, 7, 7, 2, 2'b11, 1, 1, Z, Z};  // freeze beats branch
    vecs[15] = '{0, 0, 0, 0, 2'b00, 0, 0, R, R};

    #1;
    chk("reset_u1", 16'(out1()), 16'(X));
    chk("reset_u3", 16'(out3()), 16'(X));
`ifdef HAZARD_PERF_EN
    chk("perf_stall_reset", ps3, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].mr, vecs[i].rt, vecs[i].rs0, vecs[i].rs1, vecs[i].used,
            vecs[i].br, vecs[i].busy);
      chk($sformatf("vec%0d_u1", i), 16'(out1()), 16'(vecs[i].e1));
      chk($sformatf("vec%0d_u3", i), 16'(out3()), 16'(vecs[i].e3));
    end

    // MemBusy for 4 cycles while u3 sits in LDSTALL with 2 bubbles left
    apply(1, 9, 9, 1, 2'b11, 0, 0);
    chk("busy_detect_u3", 16'(out3()), 16'(S));
    for (int i = 0; i < 4; i++) begin
      apply(0, 9, 9, 1, 2'b11, 0, 1);
      chk($sformatf("busy_hold%0d_u1", i), 16'(out1()), 16'(Z));
      chk($sformatf("busy_hold%0d_u3", i), 16'(out3()), 16'(Z));
    end
    apply(0, 9, 9, 1, 2'b11, 0, 0);
    chk("busy_rel0_u1", 16'(out1()), 16'(R));
    chk("busy_rel0_u3", 16'(out3()), 16'(S));
    apply(0, 9, 9, 1, 2'b11, 0, 0);
    chk("busy_rel1_u3", 16'(out3()), 16'(S));
    apply(0, 9, 9, 1, 2'b11, 0, 0);
    chk("busy_rel2_u3", 16'(out3()), 16'(R));

    // reset asserted in the middle of a u3 stall
    apply(1, 4, 4, 6, 2'b11, 0, 0);
    chk("rst_detect_u3", 16'(out3()), 16'(S));
    @(negedge clk);
    mr = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_mid_u1", 16'(out1()), 16'(X));
    chk("rst_mid_u3", 16'(out3()), 16'(X));
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cleared", ps3, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_u1", 16'(out1()), 16'(R));
    chk("rst_rel_u3", 16'(out3()), 16'(R));

`ifdef HAZARD_PERF_EN
    apply(1, 4, 4, 6, 2'b11, 0, 0);
    apply(0, 4, 4, 6, 2'b11, 0, 0);
    apply(0, 4, 4, 6, 2'b11, 0, 0);
    apply(0, 4, 4, 6, 2'b11, 0, 0);
    chk("perf_stall_after_one", ps3, 16'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
